// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the MEM-stage cache controller slice.
package arm_mem_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
  localparam int unsigned CACHE_ADDR_W      = 17;
  localparam int unsigned LINE_W            = 64;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned CNT_W             = 16;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR
  } cc_state_t;

endpackage

// File: rtl/cache_controller_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cache_controller.sv
// Sequences MEM-stage loads/stores between the 2-way data cache and SRAM:
// hits served from cache, misses line-filled, stores write-through with invalidate.
module cache_controller
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_r_en,
  input  logic                    mem_w_en,
  input  logic [31:0]             address,
  input  logic [WORD_W-1:0]       wdata,
  output logic [WORD_W-1:0]       rdata,
  output logic                    ready,
  output logic [CACHE_ADDR_W-1:0] cache_address,
  output logic                    cache_write_en,
  output logic                    cache_read_en,
  output logic                    cache_invoke_en,
  output logic [LINE_W-1:0]       cache_write_data,
  input  logic                    cache_hit,
  input  logic [WORD_W-1:0]       cache_read_data,
  output logic                    sram_r_en,
  output logic                    sram_w_en,
  output logic [31:0]             sram_address,
  output logic [WORD_W-1:0]       sram_wdata,
  input  logic [LINE_W-1:0]       sram_rdata,
  input  logic                    sram_ready,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);

  cc_state_t state_q;
  cc_state_t state_d;
  logic      addr_borrow;
  logic      hit_inc;
  logic      miss_inc;

  // Bits [18:2] of (address - BASE_ADDR): the byte-offset borrow is folded in
  // so the discarded low/high bits of the full 32-bit difference never exist.
  assign addr_borrow   = (address[1:0] < BASE_ADDR[1:0]);
  assign cache_address = address[18:2] - BASE_ADDR[18:2] - {{(CACHE_ADDR_W-1){1'b0}}, addr_borrow};

  assign sram_address  = address;
  assign sram_wdata    = wdata;

  always_comb begin
    state_d          = state_q;
    rdata            = '0;
    ready            = 1'b0;
    cache_write_en   = 1'b0;
    cache_read_en    = 1'b0;
    cache_invoke_en  = 1'b0;
    cache_write_data = '0;
    sram_r_en        = 1'b0;
    sram_w_en        = 1'b0;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_w_en) begin
          cache_invoke_en = 1'b1;
          sram_w_en       = 1'b1;
          state_d         = WR;
        end else if (mem_r_en) begin
          if (cache_hit) begin
            cache_read_en = 1'b1;
            rdata         = cache_read_data;
            ready         = 1'b1;
            hit_inc       = 1'b1;
          end else begin
            sram_r_en = 1'b1;
            miss_inc  = 1'b1;
            state_d   = RD_MISS;
          end
        end else begin
          ready = 1'b1;
        end
      end

      RD_MISS: begin
        if (sram_ready) begin
          cache_write_en   = 1'b1;
          cache_write_data = sram_rdata;
          rdata            = cache_address[0] ? sram_rdata[63:32] : sram_rdata[31:0];
          ready            = 1'b1;
          state_d          = IDLE;
        end else begin
          sram_r_en = 1'b1;
        end
      end

      WR: begin
        if (sram_ready) begin
          ready   = 1'b1;
          state_d = IDLE;
        end else begin
          sram_w_en = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_hit_cnt (
    .clk_i   (clk),
    .clear_i (rst),
    .inc_i   (hit_inc),
    .count_o (hit_count)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_miss_cnt (
    .clk_i   (clk),
    .clear_i (rst),
    .inc_i   (miss_inc),
    .count_o (miss_count)
  );

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: IDLE decode table plus multi-cycle
// miss/store/reset sequences, load data checked through a scoreboard queue.
module tb_cache_controller;
  import arm_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [16:0] cache_address;
  logic        cache_write_en, cache_read_en, cache_invoke_en;
  logic [63:0] cache_write_data;
  logic        cache_hit;
  logic [31:0] cache_read_data;
  logic        sram_r_en, sram_w_en;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [15:0] hit_count, miss_count;

  int total = 0;
  int bad   = 0;
  int exp_hits   = 0;
  int exp_misses = 0;
  logic [31:0] exp_q[$];
  bit sb_on = 1'b0;

  always #5 clk = ~clk;

  cache_controller #(.BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready),
    .cache_address(cache_address), .cache_write_en(cache_write_en),
    .cache_read_en(cache_read_en), .cache_invoke_en(cache_invoke_en),
    .cache_write_data(cache_write_data), .cache_hit(cache_hit),
    .cache_read_data(cache_read_data), .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    bit          r, w, hit, srdy;
    logic [31:0] addr, wd, crd;
    bit          e_ready, e_rden, e_sr, e_sw, e_inv, e_cwe;
    logic [31:0] e_rdata;
    logic [16:0] e_ca;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] ca_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - 32'd1024;
    return o[18:2];
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] a, input logic [63:0] line);
    logic [31:0] o;
    o = a - 32'd1024;
    return o[2] ? line[63:32] : line[31:0];
  endfunction

  // Scoreboard: every completed load pops the oldest expected word.
  always @(negedge clk) begin
    #2;
    if (sb_on && !rst && mem_r_en && !mem_w_en && ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got rdata %0h expected no load completion", rdata);
      end else begin
        chk("sb_rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    mem_r_en = 0; mem_w_en = 0; cache_hit = 0; sram_ready = 0;
    sram_rdata = 64'h0; cache_read_data = 32'h0;
  endtask

  task automatic load_seq(input logic [31:0] a, input bit hit, input logic [31:0] crd,
                          input int lat, input logic [63:0] line);
    @(negedge clk);
    address = a; mem_r_en = 1; cache_hit = hit; cache_read_data = crd;
    if (hit) begin
      exp_q.push_back(crd);
      exp_hits++;
      #1;
      chk("hit_ready", ready, 1);
      chk("hit_rd_en", cache_read_en, 1);
      chk("hit_no_sram_r", sram_r_en, 0);
      chk("hit_ca", cache_address, ca_of(a));
    end else begin
      exp_q.push_back(word_of(a, line));
      exp_misses++;
      for (int c = 0; c <= lat; c++) begin
        if (c > 0) @(negedge clk);
        sram_ready = (c == lat);
        sram_rdata = (c == lat) ? line : 64'h0;
        #1;
        chk("miss_ca", cache_address, ca_of(a));
        chk("miss_sram_r_en", sram_r_en, (c < lat));
        chk("miss_ready", ready, (c == lat));
        chk("miss_cwe", cache_write_en, (c == lat));
        if (c == lat) chk("miss_cwdata", cache_write_data, line);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
    chk("idle_ready", ready, 1);
  endtask

  task automatic store_seq(input logic [31:0] a, input logic [31:0] d, input int lat, input bit also_rd);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      mem_w_en = 1; mem_r_en = also_rd; cache_hit = also_rd;
      address = a; wdata = d; sram_ready = (c == lat);
      #1;
      chk("st_invoke", cache_invoke_en, (c == 0));
      chk("st_sram_w_en", sram_w_en, (c < lat));
      chk("st_ready", ready, (c == lat));
      chk("st_sram_wdata", sram_wdata, d);
      chk("st_sram_addr", sram_address, a);
      chk("st_no_rd", {sram_r_en, cache_read_en, cache_write_en}, 3'b000);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("st_hit_count", hit_count, exp_hits);
    chk("st_miss_count", miss_count, exp_misses);
  endtask

  initial begin
    //          r  w  hit srdy addr          wd            crd           rdy rden sr sw inv cwe rdata         ca
    tbl[0] = '{0, 0, 0, 0, 32'h0000_0408, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0, 32'h0,        17'h00002};
    tbl[1] = '{0, 0, 0, 1, 32'h0000_040C, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0, 32'h0,        17'h00003};
    tbl[2] = '{1, 0, 1, 0, 32'h0000_040C, 32'h0,        32'hAAAABBBB, 1, 1, 0, 0, 0, 0, 32'hAAAABBBB, 17'h00003};
    tbl[3] = '{1, 0, 0, 0, 32'h0000_0408, 32'h0,        32'h55,       0, 0, 1, 0, 0, 0, 32'h0,        17'h00002};
    tbl[4] = '{0, 1, 0, 0, 32'h0000_040C, 32'hDEADBEEF, 32'h0,        0, 0, 0, 1, 1, 0, 32'h0,        17'h00003};
    tbl[5] = '{1, 1, 1, 0, 32'h0000_0408, 32'h1,        32'h1234,     0, 0, 0, 1, 1, 0, 32'h0,        17'h00002};
    tbl[6] = '{0, 0, 0, 0, 32'h0000_0000, 32'h0,        32'h0,        1, 0, 0, 0, 0, 0, 32'h0,        17'h1FF00};
    tbl[7] = '{1, 0, 1, 0, 32'h8000_0408, 32'h0,        32'h0BADF00D, 1, 1, 0, 0, 0, 0, 32'h0BADF00D, 17'h00002};
    tbl[8] = '{1, 0, 1, 0, 32'h0008_03FC, 32'h0,        32'h600DCAFE, 1, 1, 0, 0, 0, 0, 32'h600DCAFE, 17'h1FFFF};

    idle_inputs();
    address = 32'h408; wdata = 32'h0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_enables", {cache_write_en, cache_read_en, cache_invoke_en, sram_r_en, sram_w_en}, 5'b0);
    chk("rst_rdata", rdata, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_ca_follows", cache_address, 17'h2);
    rst = 0;

    // Single-cycle IDLE decode; inputs withdrawn before the next active edge.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mem_r_en = tbl[i].r; mem_w_en = tbl[i].w; cache_hit = tbl[i].hit;
      sram_ready = tbl[i].srdy; sram_rdata = 64'hCAFEF00D_12345678;
      address = tbl[i].addr; wdata = tbl[i].wd; cache_read_data = tbl[i].crd;
      #1;
      chk($sformatf("v%0d_ready", i), ready, tbl[i].e_ready);
      chk($sformatf("v%0d_rdata", i), rdata, tbl[i].e_rdata);
      chk($sformatf("v%0d_ca", i), cache_address, tbl[i].e_ca);
      chk($sformatf("v%0d_en", i),
          {cache_read_en, sram_r_en, sram_w_en, cache_invoke_en, cache_write_en},
          {tbl[i].e_rden, tbl[i].e_sr, tbl[i].e_sw, tbl[i].e_inv, tbl[i].e_cwe});
      chk($sformatf("v%0d_saddr", i), sram_address, tbl[i].addr);
      chk($sformatf("v%0d_swdata", i), sram_wdata, tbl[i].wd);
      #2;
      idle_inputs();
    end
    @(negedge clk);
    #1;
    chk("tbl_counts_unchanged", {hit_count, miss_count}, 32'h0);

    sb_on = 1;
    load_seq(32'h408, 0, 32'h0, 4, 64'hAAAABBBB_11112222);
    load_seq(32'h40C, 1, 32'hAAAABBBB, 0, 64'h0);
    store_seq(32'h40C, 32'hDEADBEEF, 3, 0);
    store_seq(32'h408, 32'h0F0F0F0F, 2, 1);
    load_seq(32'h40C, 0, 32'h0, 1, 64'h55556666_77778888);

    // Reset while a line fill is outstanding; the late sram_ready must be ignored.
    @(negedge clk);
    address = 32'h410; mem_r_en = 1; cache_hit = 0;
    @(negedge clk);
    @(negedge clk);
    mem_r_en = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rstmiss_sram_r_en", sram_r_en, 0);
    chk("rstmiss_ready", ready, 1);
    chk("rstmiss_miss_count", miss_count, 0);
    chk("rstmiss_hit_count", hit_count, 0);
    @(negedge clk);
    sram_ready = 1; sram_rdata = 64'h99998888_77776666;
    #1;
    chk("late_sram_ready_cwe", cache_write_en, 0);
    chk("late_sram_ready_rdata", rdata, 0);
    chk("late_sram_ready_ready", ready, 1);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("post_rst_idle_ready", ready, 1);

    chk("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
